lisp_uart_console: RTL and testbench

- Memory-mapped serial console peripheral on the lisp_core register bus (register_index/read/write).
- Replaces the simulation-only character sink at register 0 with synthesizable hardware:
  - parametrised-depth TX FIFO feeding an 8N1 transmitter;
  - an 8N1 receiver with a single holding register;
  - a status register;
  - a programmable baud divisor.
- Multiple instances may share the bus at different BASE_INDEX values.

---
 rtl/lisp_uart_console_if.sv | 18 +
 rtl/lisp_uart_console.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lisp_uart_console.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lisp_uart_console_if.sv
// Register bus between lisp_core and its memory-mapped peripherals.
interface lisp_uart_console_if;
    logic [6:0]  register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;

    modport master (
        output register_index, register_read, register_write, register_write_value,
        input  register_read_value
    );

    modport slave (
        input  register_index, register_read, register_write, register_write_value,
        output register_read_value
    );
endinterface

// File: rtl/lisp_uart_console.sv
// Serial console: DATA/STATUS/DIVISOR registers, TX FIFO feeding an 8N1
// transmitter, and an 8N1 receiver with a single holding register.
module lisp_uart_console #(
    parameter int BASE_INDEX      = 0,
    parameter int FIFO_DEPTH      = 8,
    parameter int DEFAULT_DIVISOR = 16,
    parameter int DIV_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lisp_uart_console_if.slave   bus,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic                 rx_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [6:0] IDX_DATA   = 7'(BASE_INDEX);
    localparam logic [6:0] IDX_STATUS = 7'(BASE_INDEX + 1);
    localparam logic [6:0] IDX_DIV    = 7'(BASE_INDEX + 2);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIVISOR);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Register-side state
    logic [15:0]          rd_val_q, rd_val_d;
    logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_ovf_q, tx_ovf_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_frm_q, rx_frm_d;

    // TX FIFO
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty, fifo_full, tx_push, tx_pop, wr_data;
    logic [7:0]       fifo_head;

    // TX FSM
    tx_state_t            tx_state_q;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_div_q;
    logic [2:0]           tx_bit_q;
    logic [7:0]           tx_shift_q;
    logic                 uart_tx_q;

    // RX FSM
    rx_state_t            rx_state_q;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_div_q;
    logic [2:0]           rx_bit_q;
    logic [7:0]           rx_shift_q;
    logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic                 rx_fin, rx_done, rx_ferr;

    logic                 tx_idle;
    logic [15:0]          status_word;
    logic [DIV_WIDTH-1:0] div_wval;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign wr_data    = bus.register_write && (bus.register_index == IDX_DATA);
    // The FSM pops from IDLE, or at the very end of STOP to chain frames gap-free.
    assign tx_pop     = !fifo_empty &&
                        ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_cnt_q == '0));
    // A pop in the same cycle frees a slot for a push into a full FIFO.
    assign tx_push    = wr_data && (!fifo_full || tx_pop);
    assign tx_idle    = fifo_empty && (tx_state_q == TX_IDLE);

    assign rx_fin  = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
    assign rx_done = rx_fin && rx_sync2_q;
    assign rx_ferr = rx_fin && !rx_sync2_q;

    assign status_word = {8'(count_q), 2'b00, rx_frm_q, rx_ovr_q, tx_ovf_q,
                          rx_valid_q, tx_idle, fifo_full};
    assign div_wval    = bus.register_write_value[DIV_WIDTH-1:0];

    assign bus.register_read_value = rd_val_q;
    assign uart_tx = uart_tx_q;
    assign rx_irq  = rx_valid_q;

    // Bus decode, sticky status bits, RX holding register and FIFO pointers.
    always_comb begin
        rd_val_d   = rd_val_q;
        divisor_d  = divisor_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        tx_ovf_d   = tx_ovf_q;
        rx_ovr_d   = rx_ovr_q;
        rx_frm_d   = rx_frm_q;

        if (bus.register_read) begin
            if (bus.register_index == IDX_DATA) begin
                rd_val_d   = {7'b0, rx_valid_q, rx_byte_q};
                rx_valid_d = 1'b0;
            end else if (bus.register_index == IDX_STATUS) begin
                rd_val_d = status_word;
            end else if (bus.register_index == IDX_DIV) begin
                rd_val_d = 16'(divisor_q);
            end
        end

        if (bus.register_write && bus.register_index == IDX_STATUS) begin
            if (bus.register_write_value[3]) tx_ovf_d = 1'b0;
            if (bus.register_write_value[4]) rx_ovr_d = 1'b0;
            if (bus.register_write_value[5]) rx_frm_d = 1'b0;
        end
        if (bus.register_write && bus.register_index == IDX_DIV)
            divisor_d = (div_wval < DIV_MIN) ? DIV_MIN : div_wval;

        // Hardware sets come after the W1C so a coincident set wins.
        if (wr_data && !tx_push) tx_ovf_d = 1'b1;
        if (rx_done) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q) rx_ovr_d = 1'b1;
        end
        if (rx_ferr) rx_frm_d = 1'b1;

        wr_ptr_d = wr_ptr_q + PTR_W'(tx_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(tx_pop);
        count_d  = count_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end

    // Register-side state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_val_q   <= '0;
            divisor_q  <= DIV_RST;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_frm_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rd_val_q   <= rd_val_d;
            divisor_q  <= divisor_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_frm_q   <= rx_frm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr_q] <= bus.register_write_value[7:0];
    end

    // TX FSM; uart_tx is registered from the state, so the line lags the state by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_RST;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
        end else begin
            uart_tx_q <= (tx_state_q == TX_START) ? 1'b0 :
                         (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift_q <= fifo_head;
                        tx_div_q   <= divisor_q;
                        tx_cnt_q   <= divisor_q - 1'b1;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 1'b1;
                    else begin
                        tx_cnt_q   <= tx_div_q - 1'b1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 1'b1;
                    else begin
                        tx_cnt_q <= tx_div_q - 1'b1;
                        if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
                        else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 1'b1;
                    else if (tx_pop) begin
                        tx_shift_q <= fifo_head;
                        tx_div_q   <= divisor_q;
                        tx_cnt_q   <= divisor_q - 1'b1;
                        tx_state_q <= TX_START;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= uart_rx;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    // RX FSM: half-bit wait to centre on the start bit, then full-bit steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_RST;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync2_q) begin
                        rx_div_q   <= divisor_q;
                        rx_cnt_q   <= (divisor_q >> 1) - 1'b1;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
                    else if (rx_sync2_q) rx_state_q <= RX_IDLE;
                    else begin
                        rx_cnt_q   <= rx_div_q - 1'b1;
                        rx_bit_q   <= '0;
                        rx_state_q <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
                    else begin
                        rx_cnt_q   <= rx_div_q - 1'b1;
                        rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else rx_bit_q <= rx_bit_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 1'b1;
                    else rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lisp_uart_console.sv
// Self-checking bench for lisp_uart_console: random bytes through TX and RX,
// compared with a frame-level model of the serial line and register file.
module tb_lisp_uart_console;
    localparam int BASE = 4;
    localparam int DEPTH = 8;
    localparam int DEF_DIV = 16;
    localparam logic [6:0] I_DATA = 7'(BASE);
    localparam logic [6:0] I_STAT = 7'(BASE + 1);
    localparam logic [6:0] I_DIV  = 7'(BASE + 2);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx, rx_irq;

    lisp_uart_console_if bus();

    lisp_uart_console #(
        .BASE_INDEX(BASE), .FIFO_DEPTH(DEPTH),
        .DEFAULT_DIVISOR(DEF_DIV), .DIV_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Model of the register file, updated from what the bench sends.
    logic       m_rxv, m_ovf, m_ovr, m_frm;
    logic [7:0] m_rxb;
    logic [7:0] txq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] stat_exp(input int cnt, input bit busy);
        return {8'(cnt), 2'b00, m_frm, m_ovr, m_ovf, m_rxv,
                (cnt == 0 && !busy), (cnt == DEPTH)};
    endfunction

    task automatic bus_wr(input logic [6:0] idx, input logic [15:0] val);
        @(negedge clk);
        bus.register_index = idx;
        bus.register_write_value = val;
        bus.register_write = 1'b1;
        @(negedge clk);
        bus.register_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [6:0] idx, output logic [15:0] v);
        @(negedge clk);
        bus.register_index = idx;
        bus.register_read = 1'b1;
        @(negedge clk);
        bus.register_read = 1'b0;
        v = bus.register_read_value;
    endtask

    // Back-to-back DATA writes of txq[0..n-1], one per clock.
    task automatic wr_burst(input int n);
        @(negedge clk);
        bus.register_index = I_DATA;
        bus.register_write_value = {8'h00, txq[0]};
        bus.register_write = 1'b1;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            bus.register_write_value = {8'h00, txq[k]};
        end
        @(negedge clk);
        bus.register_write = 1'b0;
    endtask

    // Entered at the negedge right after the first write edge N: line stays
    // high through N+1, then nf contiguous 10*div-clock frames, then idle.
    task automatic tx_expect(input int nf, input int div);
        logic [7:0] b;
        logic e;
        chk("tx_pre0", uart_tx, 1);
        @(negedge clk);
        chk("tx_pre1", uart_tx, 1);
        for (int f = 0; f < nf; f++) begin
            b = txq[f];
            for (int bit_i = 0; bit_i < 10; bit_i++) begin
                e = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : b[bit_i-1];
                for (int c = 0; c < div; c++) begin
                    @(negedge clk);
                    chk($sformatf("tx_f%0d_b%0d", f, bit_i), uart_tx, e);
                end
            end
        end
        @(negedge clk);
        chk("tx_post", uart_tx, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (div) @(negedge clk);
        end
        uart_rx = stop;
        repeat (div) @(negedge clk);
        uart_rx = 1'b1;
        repeat (div) @(negedge clk);
        if (stop) begin
            if (m_rxv) m_ovr = 1'b1;
            m_rxv = 1'b1;
            m_rxb = b;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] v, prev;
        int div, r, nwr, acc;
        logic [7:0] b;

        bus.register_index = '0;
        bus.register_read = 1'b0;
        bus.register_write = 1'b0;
        bus.register_write_value = '0;
        m_rxv = 0; m_ovf = 0; m_ovr = 0; m_frm = 0; m_rxb = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdval", bus.register_read_value, 16'h0000);
        chk("rst_tx", uart_tx, 1);
        chk("rst_irq", rx_irq, 0);
        reset = 1'b0;
        bus_rd(I_STAT, v);  chk("rst_status", v, stat_exp(0, 0));
        bus_rd(I_DIV, v);   chk("rst_div", v, 16'(DEF_DIV));

        // Decode: other indices neither respond nor disturb the read value
        prev = v;
        bus_rd(7'd0, v);    chk("nodecode_rd", v, prev);
        bus_wr(7'(BASE + 3), 16'h0041);
        repeat (4) @(negedge clk);
        bus_rd(I_STAT, v);  chk("nodecode_wr", v, stat_exp(0, 0));

        // Single 0x55 frame at divisor 4, exact waveform
        bus_wr(I_DIV, 16'd4);
        txq = {8'h55};
        fork
            wr_burst(1);
            begin @(negedge clk); @(negedge clk); tx_expect(1, 4); end
        join
        bus_rd(I_STAT, v);  chk("tx55_idle", v, stat_exp(0, 0));

        // Random short bursts at random small divisors
        for (int t = 0; t < 3; t++) begin
            div = $urandom_range(4, 8);
            bus_wr(I_DIV, 16'(div));
            nwr = $urandom_range(1, 3);
            txq = {};
            for (int k = 0; k < nwr; k++) txq.push_back(8'($urandom));
            fork
                wr_burst(nwr);
                begin @(negedge clk); @(negedge clk); tx_expect(nwr, div); end
            join
            bus_rd(I_STAT, v);  chk("txrnd_idle", v, stat_exp(0, 0));
        end

        // Overflow: 10 back-to-back writes into an 8-deep FIFO at divisor 16
        bus_wr(I_DIV, 16'd16);
        nwr = 10;
        acc = (nwr < DEPTH + 1) ? nwr : DEPTH + 1;
        txq = {};
        for (int k = 0; k < nwr; k++) txq.push_back(8'($urandom));
        fork
            begin
                wr_burst(nwr);
                m_ovf = (nwr > acc);
                bus_rd(I_STAT, v);  chk("ovf_status", v, stat_exp(acc - 1, 1));
                bus_wr(I_STAT, 16'h0008);
                m_ovf = 1'b0;
                bus_rd(I_STAT, v);  chk("ovf_w1c", v, stat_exp(acc - 1, 1));
            end
            begin @(negedge clk); @(negedge clk); tx_expect(acc, 16); end
        join
        bus_rd(I_STAT, v);  chk("ovf_idle", v, stat_exp(0, 0));

        // RX: fixed 0xA3 then random bytes, each read back through DATA
        for (int t = 0; t < 5; t++) begin
            b = (t == 0) ? 8'hA3 : 8'($urandom);
            send_rx(b, 1'b1, 16);
            chk("rx_irq_set", rx_irq, 1);
            bus_rd(I_DATA, v);
            chk("rx_data", v, {7'b0, m_rxv, m_rxb});
            m_rxv = 1'b0;
            chk("rx_irq_clr", rx_irq, 0);
        end

        // Overrun
        send_rx(8'h11, 1'b1, 16);
        send_rx(8'h22, 1'b1, 16);
        bus_rd(I_STAT, v);  chk("ovr_status", v, stat_exp(0, 0));
        bus_rd(I_DATA, v);  chk("ovr_data", v, {7'b0, m_rxv, m_rxb});
        m_rxv = 1'b0;
        bus_wr(I_STAT, 16'h0010);
        m_ovr = 1'b0;
        bus_rd(I_STAT, v);  chk("ovr_w1c", v, stat_exp(0, 0));

        // Framing error
        send_rx(8'h5A, 1'b0, 16);
        chk("frm_irq", rx_irq, 0);
        bus_rd(I_STAT, v);  chk("frm_status", v, stat_exp(0, 0));
        bus_wr(I_STAT, 16'h0020);
        m_frm = 1'b0;
        bus_rd(I_STAT, v);  chk("frm_w1c", v, stat_exp(0, 0));

        // 3-clock glitch is a false start
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_irq", rx_irq, 0);
        bus_rd(I_STAT, v);  chk("glitch_status", v, stat_exp(0, 0));

        // Divisor clamping
        bus_wr(I_DIV, 16'd2);
        bus_rd(I_DIV, v);   chk("div_clamp", v, 16'd4);
        for (int t = 0; t < 3; t++) begin
            r = $urandom_range(0, 40);
            bus_wr(I_DIV, 16'(r));
            bus_rd(I_DIV, v);  chk("div_rnd", v, 16'((r < 4) ? 4 : r));
        end

        // Reset mid-frame
        bus_wr(I_DIV, 16'd20);
        bus_wr(I_DATA, 16'h0000);
        repeat (30) @(negedge clk);
        chk("mid_frame_low", uart_tx, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", uart_tx, 1);
        reset = 1'b0;
        m_rxv = 0; m_ovf = 0; m_ovr = 0; m_frm = 0;
        bus_rd(I_STAT, v);  chk("rst_mid_status", v, 16'h0002);
        bus_rd(I_DIV, v);   chk("rst_mid_div", v, 16'(DEF_DIV));
        chk("rst_mid_irq", rx_irq, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
